// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath and pipe_hazard_ctrl.
// Optional HAZARD_PERF_EN adds the stall/flush performance counters.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0] inst_D;
    logic [31:0] inst_E;
    logic        reg_wr_E;
    logic        rd_en_E;
    logic        jump_E;
    logic        br_taken_E;
    logic        mem_busy;
    logic        stall_F;
    logic        stall_D;
    logic        stall_E;
    logic        stall_M;
    logic        flush_D;
    logic        flush_E;
    logic [1:0]  fwd_a_E;
    logic [1:0]  fwd_b_E;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport master (
        output inst_D, inst_E, reg_wr_E, rd_en_E, jump_E, br_taken_E, mem_busy,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, fwd_a_E, fwd_b_E
`ifdef HAZARD_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  inst_D, inst_E, reg_wr_E, rd_en_E, jump_E, br_taken_E, mem_busy,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, fwd_a_E, fwd_b_E
`ifdef HAZARD_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage pipeline, consuming the D/E register.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
    parameter int IMEM_LAT = 0,
    parameter int CNT_W    = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CW = (IMEM_LAT > 1) ? $clog2(IMEM_LAT + 1) : 1;

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    rd_M, rd_W;
    logic          wr_M, wr_W;

    logic [4:0] rs1_D, rs2_D, rd_E, rs1_E, rs2_E;
    logic       load_use, redirect;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

    assign rs1_D = hz.inst_D[19:15];
    assign rs2_D = hz.inst_D[24:20];
    assign rd_E  = hz.inst_E[11:7];
    assign rs1_E = hz.inst_E[19:15];
    assign rs2_E = hz.inst_E[24:20];

    logic unused_bits;
    assign unused_bits = ^{hz.inst_D[31:25], hz.inst_D[14:0], hz.inst_E[31:25], hz.inst_E[6:0]};

    assign load_use = hz.rd_en_E & hz.reg_wr_E & (rd_E != 5'd0) &
                      ((rd_E == rs1_D) | (rd_E == rs2_D));
    assign redirect = hz.jump_E | hz.br_taken_E;

    // M-stage result is younger than W, so it wins when both match
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic wrm,
                                           input logic [4:0] rdw, input logic wrw);
        if (wrm && rdm != 5'd0 && rdm == rs)      return 2'b01;
        else if (wrw && rdw != 5'd0 && rdw == rs) return 2'b10;
        else                                      return 2'b00;
    endfunction

    assign hz.fwd_a_E = fwd_sel(rs1_E, rd_M, wr_M, rd_W, wr_W);
    assign hz.fwd_b_E = fwd_sel(rs2_E, rd_M, wr_M, rd_W, wr_W);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (hz.mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (state == REDIRECT) begin
            flush_d = 1'b1;
        end else if (redirect) begin
            // the D-stage instruction is wrong-path, so any load-use against it is moot
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.stall_F = stall_f;
    assign hz.stall_D = stall_d;
    assign hz.stall_E = stall_e;
    assign hz.stall_M = stall_m;
    assign hz.flush_D = flush_d;
    assign hz.flush_E = flush_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            rd_M  <= 5'd0;
            rd_W  <= 5'd0;
            wr_M  <= 1'b0;
            wr_W  <= 1'b0;
        end else if (!hz.mem_busy) begin
            rd_M <= rd_E;
            wr_M <= hz.reg_wr_E & ~redirect;
            rd_W <= rd_M;
            wr_W <= wr_M;
            case (state)
                RUN: begin
                    if (redirect && IMEM_LAT > 0) begin
                        state <= REDIRECT;
                        cnt   <= CW'(IMEM_LAT);
                    end
                end
                REDIRECT: begin
                    if (cnt <= CW'(1)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // free-running, wraps modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f) stall_cnt <= stall_cnt + 1'b1;
            if (flush_e) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Consumer-side controller for the decode/execute pipeline register.
- Reads the execute-stage control and instruction fields that register delivers, plus decode-stage source registers.
- Generates stall and flush for the F/D, D/E and E/M pipeline registers, and forwarding selects for the execute operand muxes.
- Holds shadow copies of the destination register and write-enable for the M and W stages, plus a small redirect state machine.

Parameters:
- IMEM_LAT, 0: extra fetch-latency cycles; flush_D stays asserted this many extra cycles after a redirect.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inst_D  in  32  decode-stage instruction; rs1=[19:15], rs2=[24:20]
- inst_E  in  32  execute-stage instruction from D/E register; rd=[11:7], rs1, rs2
- reg_wr_E  in  1  execute-stage instruction writes the register file
- rd_en_E  in  1  execute-stage instruction is a load
- jump_E  in  1  execute-stage jump
- br_taken_E  in  1  execute-stage branch resolved taken
- mem_busy  in  1  data memory wait request; freezes the whole pipeline
- stall_F  out  1  hold PC
- stall_D  out  1  hold the F/D register
- stall_E  out  1  hold the D/E register
- stall_M  out  1  hold the E/M register
- flush_D  out  1  clear the F/D register (bubble)
- flush_E  out  1  clear the D/E register (bubble)
- fwd_a_E  out  2  operand A select: 00 regfile, 01 from M, 10 from W
- fwd_b_E  out  2  operand B select, same encoding

Behaviour:
- Reset: state=RUN, redirect counter=0, rd_M=rd_W=0, wr_M=wr_W=0. All outputs 0.
- Shadow pipeline update on each clk edge:
  - If mem_busy: hold all shadows.
  - Else: rd_M<=inst_E[11:7]; wr_M<=reg_wr_E & ~redirect; rd_W<=rd_M; wr_W<=wr_M.
- Forwarding (combinational from shadows and inst_E):
  - fwd_a_E=01 if wr_M, rd_M!=0 and rd_M==rs1_E.
  - Else fwd_a_E=10 if wr_W, rd_W!=0 and rd_W==rs1_E.
  - Else fwd_a_E=00. M has priority over W.
  - fwd_b_E: same rule using rs2_E.
- Event definitions:
  - load_use = rd_en_E & reg_wr_E & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D).
  - redirect = jump_E | br_taken_E.
- Priority (highest first): mem_busy, redirect, load_use.
- mem_busy: stall_F=stall_D=stall_E=stall_M=1 and both flushes 0. State and counter are frozen.
- State RUN:
  - redirect: flush_D=flush_E=1; load_use is ignored (wrong-path instruction). If IMEM_LAT>0, counter<=IMEM_LAT and go to REDIRECT; else stay in RUN.
  - load_use only: stall_F=stall_D=1 and flush_E=1 for exactly one cycle. Next cycle E holds the bubble, so there is no re-detection. The dependent instruction then gets fwd=10 from W.
- State REDIRECT:
  - flush_D=1 each cycle while counter decrements; return to RUN when counter reaches 1.
  - A new redirect cannot arise here, since E holds bubbles.
  - load_use is masked.
- Outputs are combinational from state and inputs, so latency is 0 cycles: a hazard asserted in cycle N is acted on at the clk edge ending cycle N.
- Async rst mid-redirect or mid-stall returns immediately to the reset values above.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], both reset to 0.
  - stall_cnt increments on each cycle with stall_F=1.
  - flush_cnt increments on each cycle with flush_E=1.
  - Both wrap modulo 2^CNT_W; no saturation.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- ALU chain: add x5 then add x6,x5,x1 back-to-back -> in the second instruction's E cycle fwd_a_E=01, fwd_b_E=00, no stall.
- Load-use: lw x7 in E (rd_en_E=1, reg_wr_E=1), inst_D rs2=x7 -> stall_F=stall_D=flush_E=1 for one cycle; next cycle all stalls 0, fwd_b_E=10.
- x0 target: reg_wr_E=1, rd=x0, D reads x0 -> no stall, and fwd stays 00 in later cycles.
- Taken branch with IMEM_LAT=2 and a load_use condition present in the same cycle -> flush_D=flush_E=1 and no stall; then flush_D=1 for 2 more cycles; then RUN.
- mem_busy=1 for 3 cycles during a forwarding window -> all four stalls 1, flushes 0, fwd values unchanged throughout; normal flow resumes after release.
- rst pulse while in REDIRECT with counter=2 -> all outputs 0 immediately; after rst release no residual flush_D.
